// File: rtl/uart_cmd_sender.sv
// uart_cmd_sender
//   Maps 3-bit game command codes to the ASCII characters understood by the
//   UART command decoder, queues them in a small FIFO and sends each one as
//   an 8N1 frame (start, 8 data bits LSB first, stop) on TX.
//
// Ports
//   Pclk        clock; all state updates on its rising edge
//   RESET       synchronous active-high reset (flushes FIFO, aborts frame)
//   cmd_valid   a command is present on cmd_code
//   cmd_code    3-bit command code
//   cmd_ready   FIFO can accept a command (== !fifo_full)
//   TX          registered UART serial output, idle high
//   busy        serialiser is sending a frame
//   fifo_full   FIFO holds 2**FIFO_AW characters
//   fifo_empty  FIFO holds no characters
//   drop_count  saturating count of commands rejected while full
module uart_cmd_sender #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_AW      = 2
) (
   input  logic       Pclk,
   input  logic       RESET,
   input  logic       cmd_valid,
   input  logic [2:0] cmd_code,
   output logic       cmd_ready,
   output logic       TX,
   output logic       busy,
   output logic       fifo_full,
   output logic       fifo_empty,
   output logic [7:0] drop_count
);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int CW    = FIFO_AW + 1;
   localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   function automatic logic [7:0] code_to_ascii(input logic [2:0] code);
      logic [7:0] ch;
      case (code)
         3'd0:    ch = 8'h57;  // W
         3'd1:    ch = 8'h53;  // S
         3'd2:    ch = 8'h41;  // A
         3'd3:    ch = 8'h44;  // D
         3'd4:    ch = 8'h20;  // space (black)
         3'd5:    ch = 8'h43;  // C
         3'd6:    ch = 8'h4D;  // M
         default: ch = 8'h59;  // Y
      endcase
      return ch;
   endfunction

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [7:0]         drop_q, drop_d;
   state_t             state_q, state_d;
   logic [7:0]         shift_q, shift_d;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic [BW-1:0]      baud_q, baud_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic               push, pop, baud_done;

   // Flags come from the registered count only, so a full FIFO refuses a
   // push even in a cycle where the serialiser is popping.
   assign fifo_full  = (count_q == CNT_FULL);
   assign fifo_empty = (count_q == '0);
   assign cmd_ready  = !fifo_full;
   assign TX         = tx_q;
   assign busy       = busy_q;
   assign drop_count = drop_q;

   always_comb begin
      push      = cmd_valid && !fifo_full;
      pop       = (state_q == IDLE) && !fifo_empty;
      baud_done = (baud_q == BAUD_LAST);

      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      drop_d    = drop_q;
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      baud_d    = baud_q;
      tx_d      = tx_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (cmd_valid && !push && (drop_q != 8'hFF)) drop_d = drop_q + 1'b1;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (pop) begin
               shift_d   = mem[rd_ptr_q];
               bit_cnt_d = '0;
               baud_d    = '0;
               tx_d      = 1'b0;
               state_d   = START;
            end
         end
         START: begin
            if (baud_done) begin
               baud_d  = '0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_d    = '0;
               shift_d   = {1'b0, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  // next data bit is the one about to shift into bit 0
                  tx_d = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin  // STOP
            if (baud_done) begin
               baud_d  = '0;
               tx_d    = 1'b1;
               state_d = IDLE;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Pclk) begin
      if (RESET) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         drop_q    <= '0;
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         baud_q    <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         drop_q    <= drop_d;
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         baud_q    <= baud_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge Pclk) begin
      if (push && !RESET) mem[wr_ptr_q] <= code_to_ascii(cmd_code);
   end

endmodule
